// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu : multiply/divide unit with HI/LO registers and a fixed-latency busy
//       window (MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu).
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low reset
//   MDUOp  in   4   E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                   5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 none
//   Req    in   1   flush of the current E-stage instruction
//   A      in  32   rs operand
//   B      in  32   rt operand
//   busy   out  1   multiply/divide in flight
//   start  out  1   a new multiply/divide is accepted this cycle
//   out    out 32   HI for mfhi, LO for mflo, otherwise 0
// ---------------------------------------------------------------------------
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        start,
  output logic [31:0] out
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  logic [31:0] hi, lo;
  logic [31:0] tmp_hi, tmp_lo;
  logic [3:0]  counter;
  logic        skip_commit;   // pending result is a divide by zero

  mdu_op_e     op;
  logic        is_mul, is_div;
  logic [31:0] res_hi, res_lo;
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur;

  assign op     = mdu_op_e'(MDUOp);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign busy   = (counter != '0);
  assign start  = (is_mul || is_div) && !Req && !busy;

  // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0 rather than relying on simulator behaviour.
  always_comb begin
    prod    = '0;
    a_neg   = 1'b0;
    b_neg   = 1'b0;
    ua      = A;
    ub      = B;
    res_hi  = '0;
    res_lo  = '0;
    if (op == OP_MULT)
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      prod = {32'd0, A} * {32'd0, B};
    if (op == OP_DIV) begin
      a_neg = A[31];
      b_neg = B[31];
      ua    = a_neg ? 32'(-A) : A;
      ub    = b_neg ? 32'(-B) : B;
    end
    ub_safe = (ub == '0) ? 32'd1 : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      res_lo = (a_neg ^ b_neg) ? 32'(-uq) : uq;
      res_hi = a_neg ? 32'(-ur) : ur;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi          <= '0;
      lo          <= '0;
      tmp_hi      <= '0;
      tmp_lo      <= '0;
      counter     <= '0;
      skip_commit <= 1'b0;
    end else if (busy) begin
      // In flight: new ops are ignored, Req has no effect on completion.
      if (counter == 4'd1) begin
        if (!skip_commit) begin
          hi <= tmp_hi;
          lo <= tmp_lo;
        end
        counter <= '0;
      end else begin
        counter <= counter - 4'd1;
      end
    end else if (start) begin
      tmp_hi      <= res_hi;
      tmp_lo      <= res_lo;
      skip_commit <= is_div && (B == '0);
      counter     <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    end else if (!Req) begin
      if (op == OP_MTHI) hi <= A;
      if (op == OP_MTLO) lo <= A;
    end
  end

  always_comb begin
    out = '0;
    case (op)
      OP_MFHI: out = hi;
      OP_MFLO: out = lo;
      default: out = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu : directed self-checking bench for mdu.
// ---------------------------------------------------------------------------
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Req;
  logic [31:0] A, B;
  logic        busy, start;
  logic [31:0] out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .MDUOp (MDUOp),
    .Req   (Req),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .start (start),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    MDUOp = 4'd5; #1; check({tag, "_hi"}, out, exp_hi);
    MDUOp = 4'd6; #1; check({tag, "_lo"}, out, exp_lo);
    MDUOp = 4'd0; #1;
  endtask

  // Issue op, verify start, then verify busy is high for exactly n cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned n);
    MDUOp = op; A = a; B = b; Req = 1'b0;
    #1; check({tag, "_start"}, 32'(start), 32'd1);
    step();
    MDUOp = 4'd0;
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      step();
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; MDUOp = 4'd5; Req = 1'b0; A = '0; B = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", out, 32'd0);
    reset = 1'b1;
    MDUOp = 4'd0;
    step();

    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5);
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5);
    read_hilo("multu", 32'd2, 32'hFFFFFFFA);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
    read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 4'd4, 32'd7, 32'd2, 10);
    read_hilo("divu", 32'd1, 32'd3);

    // mthi then divide by zero: HI/LO keep their values
    MDUOp = 4'd7; A = 32'h12345678; step();
    run_op("div0", 4'd3, 32'd99, 32'd0, 10);
    read_hilo("div0", 32'h12345678, 32'd3);

    run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
    read_hilo("divovf", 32'd0, 32'h80000000);

    // flushed mult does nothing
    MDUOp = 4'd1; A = 32'd4; B = 32'd5; Req = 1'b1;
    #1; check("req_start", 32'(start), 32'd0);
    step();
    MDUOp = 4'd0; Req = 1'b0;
    check("req_busy", 32'(busy), 32'd0);
    read_hilo("req", 32'd0, 32'h80000000);

    // flushed mtlo does nothing
    MDUOp = 4'd8; A = 32'hABCD; Req = 1'b1; step();
    Req = 1'b0;
    read_hilo("req_mtlo", 32'd0, 32'h80000000);

    // Req during in-flight mult still commits
    MDUOp = 4'd1; A = 32'd4; B = 32'd5; #1;
    check("fl_start", 32'(start), 32'd1);
    step();
    MDUOp = 4'd0; Req = 1'b1;
    repeat (5) step();
    Req = 1'b0;
    check("fl_done", 32'(busy), 32'd0);
    read_hilo("fl", 32'd0, 32'd20);

    // mthi mid-operation ignored; mfhi during busy returns old HI
    MDUOp = 4'd1; A = 32'hFFFFFFFE; B = 32'd3; step();
    MDUOp = 4'd7; A = 32'hDEADBEEF; #1;
    check("mid_out7", out, 32'd0);
    step();
    MDUOp = 4'd5; #1;
    check("mid_mfhi", out, 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    MDUOp = 4'd0;
    repeat (4) step();
    check("mid_done", 32'(busy), 32'd0);
    read_hilo("mid", 32'hFFFFFFFF, 32'hFFFFFFFA);

    // unused opcode reads 0
    MDUOp = 4'd9; #1; check("op9_out", out, 32'd0);
    MDUOp = 4'd0;

    // async reset in cycle 3 of a div
    MDUOp = 4'd3; A = 32'd100; B = 32'd7; step();
    MDUOp = 4'd0;
    repeat (2) step();
    #2; reset = 1'b0; #1;
    check("ar_busy", 32'(busy), 32'd0);
    read_hilo("ar", 32'd0, 32'd0);
    @(negedge clk); reset = 1'b1;
    MDUOp = 4'd8; A = 32'd5; step();
    MDUOp = 4'd0;
    read_hilo("ar_mtlo", 32'd0, 32'd5);
    repeat (12) step();
    check("ar_nocommit_busy", 32'(busy), 32'd0);
    read_hilo("ar_nocommit", 32'd0, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
